// File: rtl/period_meter_if.sv
// Signal-side bundle for period_meter: measured input, controls and results.
// The master drives sig_in/enable/clear_ovf; the slave returns measurements.
interface period_meter_if #(
  parameter int CNT_W = 16
);
  logic             sig_in;
  logic             enable;
  logic             clear_ovf;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             overflow;

  modport master (
    output sig_in, enable, clear_ovf,
    input  period, high_time, valid, overflow
  );

  modport slave (
    input  sig_in, enable, clear_ovf,
    output period, high_time, valid, overflow
  );
endinterface

// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous input in clk cycles.
// Counters saturate into a sticky overflow instead of wrapping.
module period_meter #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  period_meter_if.slave bus
);
  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_ovf;
  logic             w_rise;

  assign w_rise = r_s2 & ~r_s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s3     <= 1'b0;
      r_cnt    <= '0;
      r_hcnt   <= '0;
      r_period <= '0;
      r_high   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_s1    <= bus.sig_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= 1'b0;
      // A saturation below on this same cycle overrides the clear.
      if (bus.clear_ovf) begin
        r_ovf <= 1'b0;
      end
      if (!bus.enable) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_hcnt  <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_rise) begin
              r_state <= MEASURE;
              r_cnt   <= ONE;
              r_hcnt  <= ONE;
            end
          end
          MEASURE: begin
            if (w_rise) begin
              r_period <= r_cnt;
              r_high   <= r_hcnt;
              r_valid  <= 1'b1;
              r_cnt    <= ONE;
              r_hcnt   <= ONE;
            end else if (r_cnt == MAX) begin
              r_ovf   <= 1'b1;
              r_state <= IDLE;
              r_cnt   <= '0;
              r_hcnt  <= '0;
            end else begin
              r_cnt <= r_cnt + ONE;
              if (r_s2) begin
                r_hcnt <= r_hcnt + ONE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.period    = r_period;
  assign bus.high_time = r_high;
  assign bus.valid     = r_valid;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: a 16-bit and a 4-bit instance share one stimulus.
// Expected results come from an edge-list model of the driven waveform.
module tb_period_meter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  period_meter_if #(.CNT_W(16)) b16 ();
  period_meter_if #(.CNT_W(4))  b4 ();

  period_meter #(.CNT_W(16)) dut16 (.clk(clk), .reset(rst), .bus(b16));
  period_meter #(.CNT_W(4))  dut4  (.clk(clk), .reset(rst), .bus(b4));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  int q16p[$], q16h[$], q16c[$];
  int q4p[$], q4h[$], q4c[$];

  always @(negedge clk) begin
    if (b16.valid === 1'b1) begin
      q16p.push_back(int'(b16.period));
      q16h.push_back(int'(b16.high_time));
      q16c.push_back(cyc);
    end
    if (b4.valid === 1'b1) begin
      q4p.push_back(int'(b4.period));
      q4h.push_back(int'(b4.high_time));
      q4c.push_back(cyc);
    end
  end

  task automatic drv(input bit s, input bit e, input bit c);
    b16.sig_in = s;
    b4.sig_in = s;
    b16.enable = e;
    b4.enable = e;
    b16.clear_ovf = c;
    b4.clear_ovf = c;
  endtask

  task automatic clear_q();
    q16p.delete(); q16h.delete(); q16c.delete();
    q4p.delete(); q4h.delete(); q4c.delete();
  endtask

  task automatic restart();
    rst = 1'b1;
    drv(1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_q();
  endtask

  // Slot i is applied just after edge c0+i+1; results sampled after edge c0+L.
  task automatic drive(input bit pat[$], input bit en[$]);
    for (int i = 0; i < pat.size(); i++) begin
      @(posedge clk);
      #1 drv(pat[i], en[i], 1'b0);
    end
    @(negedge clk);
    #1;
  endtask

  // Reference: list rising edges of the waveform; each pair of consecutive
  // rises is one measurement reported 4 edges after the later rise.
  function automatic void model(input bit pat[$], input int maxc,
                                output int ep[$], output int eh[$],
                                output int ec[$], output bit eo);
    int  last;
    int  h;
    bit  prev;
    bit  rise;
    ep.delete(); eh.delete(); ec.delete();
    eo = 1'b0;
    last = -1;
    prev = 1'b0;
    for (int i = 0; i <= pat.size() - 4; i++) begin
      rise = pat[i] && !prev;
      prev = pat[i];
      if (rise) begin
        if (last >= 0) begin
          h = 0;
          for (int j = last; j < i; j++) h += int'(pat[j]);
          ep.push_back(i - last);
          eh.push_back(h);
          ec.push_back(i + 4);
        end
        last = i;
      end else if (last >= 0 && i - last == maxc) begin
        eo = 1'b1;
        last = -1;
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drv(1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b16.period !== '0) begin
      errors++; $display("FAIL reset_period got=%0d want=0", b16.period);
    end
    checks++;
    if (b16.high_time !== '0) begin
      errors++; $display("FAIL reset_high got=%0d want=0", b16.high_time);
    end
    checks++;
    if (b16.valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b want=0", b16.valid);
    end
    checks++;
    if (b16.overflow !== 1'b0 || b4.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got=%b/%b want=0/0", b16.overflow, b4.overflow);
    end
    checks++;
    if (b4.period !== '0 || b4.high_time !== '0 || b4.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_narrow got p=%0d h=%0d v=%b want 0/0/0",
               b4.period, b4.high_time, b4.valid);
    end
  endtask

  task automatic test_square();
    bit pat[$], en[$];
    int c0;
    restart();
    for (int i = 0; i < 60; i++) pat.push_back((i % 10) < 5);
    repeat (4) pat.push_back(1'b0);
    foreach (pat[i]) en.push_back(1'b1);
    c0 = cyc;
    drive(pat, en);
    checks++;
    if (q16p.size() != 5 || q4p.size() != 5) begin
      errors++;
      $display("FAIL square_count got=%0d/%0d want=5/5", q16p.size(), q4p.size());
    end else begin
      checks++;
      if (q16c[0] - c0 != 14) begin
        errors++; $display("FAIL square_latency got=%0d want=14", q16c[0] - c0);
      end
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (q16p[k] != 10 || q16h[k] != 5 || q4p[k] != 10 || q4h[k] != 5) begin
          errors++;
          $display("FAIL square_%0d got p=%0d h=%0d p4=%0d h4=%0d want 10/5",
                   k, q16p[k], q16h[k], q4p[k], q4h[k]);
        end
      end
    end
  endtask

  task automatic test_duty_min();
    bit pat[$], en[$];
    int wp, wh;
    restart();
    for (int i = 0; i < 40; i++) pat.push_back((i % 10) < 3);
    for (int i = 0; i < 12; i++) pat.push_back((i % 2) == 0);
    repeat (4) pat.push_back(1'b0);
    foreach (pat[i]) en.push_back(1'b1);
    drive(pat, en);
    checks++;
    if (q16p.size() != 9) begin
      errors++; $display("FAIL duty_count got=%0d want=9", q16p.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        wp = (k < 4) ? 10 : 2;
        wh = (k < 4) ? 3 : 1;
        checks++;
        if (q16p[k] != wp || q16h[k] != wh) begin
          errors++;
          $display("FAIL duty_%0d got p=%0d h=%0d want p=%0d h=%0d",
                   k, q16p[k], q16h[k], wp, wh);
        end
      end
    end
  endtask

  task automatic test_overflow();
    restart();
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1 drv(1'b1, 1'b1, 1'b0);
    end
    checks++;
    if (b4.overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set got=%b want=1", b4.overflow);
    end
    checks++;
    if (q4p.size() != 0 || b4.period !== '0) begin
      errors++;
      $display("FAIL ovf_novalid got n=%0d p=%0d want 0/0", q4p.size(), b4.period);
    end
    checks++;
    if (b16.overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_wide got=%b want=0", b16.overflow);
    end
    @(posedge clk);
    #1 drv(1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1 drv(1'b1, 1'b1, 1'b0);
    checks++;
    if (b4.overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got=%b want=0", b4.overflow);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 drv(1'b0, 1'b1, 1'b0);
    end
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1 drv(1'b1, 1'b1, k == 17);
    end
    checks++;
    if (b4.overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_setwins got=%b want=1", b4.overflow);
    end
    checks++;
    if (q4p.size() != 0) begin
      errors++; $display("FAIL ovf_novalid2 got=%0d want=0", q4p.size());
    end
  endtask

  task automatic test_max_period();
    bit pat[$], en[$];
    restart();
    for (int i = 0; i < 31; i++) pat.push_back((i % 15) == 0);
    repeat (4) pat.push_back(1'b0);
    foreach (pat[i]) en.push_back(1'b1);
    drive(pat, en);
    checks++;
    if (q4p.size() != 2) begin
      errors++; $display("FAIL max_count got=%0d want=2", q4p.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (q4p[k] != 15 || q4h[k] != 1) begin
          errors++;
          $display("FAIL max_%0d got p=%0d h=%0d want 15/1", k, q4p[k], q4h[k]);
        end
      end
    end
    checks++;
    if (b4.overflow !== 1'b0) begin
      errors++; $display("FAIL max_ovf got=%b want=0", b4.overflow);
    end
  endtask

  task automatic test_enable_drop();
    bit pat[$], en[$];
    int c0;
    restart();
    for (int i = 0; i < 36; i++) begin
      pat.push_back((i % 8) < 4);
      en.push_back(i < 28);
    end
    drive(pat, en);
    checks++;
    if (q16p.size() != 3) begin
      errors++; $display("FAIL endrop_count got=%0d want=3", q16p.size());
    end
    checks++;
    if (b16.period !== 16'd8 || b16.high_time !== 16'd4) begin
      errors++;
      $display("FAIL endrop_hold got p=%0d h=%0d want 8/4", b16.period, b16.high_time);
    end
    clear_q();
    pat.delete();
    en.delete();
    for (int j = 0; j < 40; j++) begin
      pat.push_back(((j + 5) % 10) < 5);
      en.push_back(1'b1);
    end
    repeat (4) begin
      pat.push_back(1'b0);
      en.push_back(1'b1);
    end
    c0 = cyc;
    drive(pat, en);
    checks++;
    if (q16p.size() != 3) begin
      errors++; $display("FAIL reen_count got=%0d want=3", q16p.size());
    end else begin
      checks++;
      if (q16c[0] - c0 != 19 || q16p[0] != 10 || q16h[0] != 5) begin
        errors++;
        $display("FAIL reen_first got c=%0d p=%0d h=%0d want 19/10/5",
                 q16c[0] - c0, q16p[0], q16h[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    bit pat[$], en[$];
    int c0;
    restart();
    for (int i = 0; i < 30; i++) pat.push_back((i % 10) < 5);
    foreach (pat[i]) en.push_back(1'b1);
    drive(pat, en);
    checks++;
    if (b16.period !== 16'd10) begin
      errors++; $display("FAIL arst_pre got=%0d want=10", b16.period);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (b16.period !== '0 || b16.high_time !== '0 || b16.valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate got p=%0d h=%0d v=%b want 0/0/0",
               b16.period, b16.high_time, b16.valid);
    end
    drv(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_q();
    pat.delete();
    en.delete();
    for (int i = 0; i < 30; i++) pat.push_back((i % 10) < 5);
    repeat (4) pat.push_back(1'b0);
    foreach (pat[i]) en.push_back(1'b1);
    c0 = cyc;
    drive(pat, en);
    checks++;
    if (q16p.size() != 2) begin
      errors++; $display("FAIL arst_count got=%0d want=2", q16p.size());
    end else begin
      checks++;
      if (q16c[0] - c0 != 14 || q16p[0] != 10 || q16h[0] != 5) begin
        errors++;
        $display("FAIL arst_first got c=%0d p=%0d h=%0d want 14/10/5",
                 q16c[0] - c0, q16p[0], q16h[0]);
      end
    end
  endtask

  task automatic test_random();
    bit pat[$], en[$];
    int ep[$], eh[$], ec[$];
    bit eo;
    int c0, n, h, l;
    for (int t = 0; t < 12; t++) begin
      restart();
      pat.delete();
      en.delete();
      n = int'($urandom_range(3, 0));
      repeat (n) pat.push_back(1'b0);
      for (int s = 0; s < 6; s++) begin
        h = int'($urandom_range(8, 1));
        l = ($urandom_range(4, 0) == 0) ? int'($urandom_range(20, 12))
                                        : int'($urandom_range(8, 1));
        repeat (h) pat.push_back(1'b1);
        repeat (l) pat.push_back(1'b0);
      end
      repeat (4) pat.push_back(1'b0);
      foreach (pat[i]) en.push_back(1'b1);
      c0 = cyc;
      drive(pat, en);
      model(pat, 65535, ep, eh, ec, eo);
      checks++;
      if (q16p.size() != ep.size() || b16.overflow !== eo) begin
        errors++;
        $display("FAIL rnd16_%0d got n=%0d o=%b want n=%0d o=%b",
                 t, q16p.size(), b16.overflow, ep.size(), eo);
      end else begin
        for (int k = 0; k < ep.size(); k++) begin
          checks++;
          if (q16p[k] != ep[k] || q16h[k] != eh[k] || q16c[k] - c0 != ec[k]) begin
            errors++;
            $display("FAIL rnd16_%0d_%0d got p=%0d h=%0d c=%0d want p=%0d h=%0d c=%0d",
                     t, k, q16p[k], q16h[k], q16c[k] - c0, ep[k], eh[k], ec[k]);
          end
        end
      end
      model(pat, 15, ep, eh, ec, eo);
      checks++;
      if (q4p.size() != ep.size() || b4.overflow !== eo) begin
        errors++;
        $display("FAIL rnd4_%0d got n=%0d o=%b want n=%0d o=%b",
                 t, q4p.size(), b4.overflow, ep.size(), eo);
      end else begin
        for (int k = 0; k < ep.size(); k++) begin
          checks++;
          if (q4p[k] != ep[k] || q4h[k] != eh[k] || q4c[k] - c0 != ec[k]) begin
            errors++;
            $display("FAIL rnd4_%0d_%0d got p=%0d h=%0d c=%0d want p=%0d h=%0d c=%0d",
                     t, k, q4p[k], q4h[k], q4c[k] - c0, ep[k], eh[k], ec[k]);
          end
        end
      end
    end
  endtask

  initial begin
    drv(1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_square();
    test_duty_min();
    test_overflow();
    test_max_period();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
